// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite encodings plus the bridge state type and lane/size helpers.
package ahb3lite_pkg;

  localparam int HTRANS_SIZE = 2;
  localparam int HSIZE_SIZE  = 3;
  localparam int HBURST_SIZE = 3;
  localparam int HPROT_SIZE  = 4;

  localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [HSIZE_SIZE-1:0] HSIZE_BYTE  = 3'b000;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_HWORD = 3'b001;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_WORD  = 3'b010;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

  // Which APB-wide slice of the AHB data bus the byte address selects.
  function automatic int unsigned lane_index(input logic [31:0] addr,
                                             input int unsigned hbytes,
                                             input int unsigned pbytes);
    return (addr % hbytes) / pbytes;
  endfunction

  function automatic logic size_legal(input logic [HSIZE_SIZE-1:0] hsize,
                                      input int unsigned pbytes);
    return (32'd1 << hsize) <= pbytes;
  endfunction

endpackage

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave that turns single AHB transfers into APB3 accesses on the
// same clock, narrowing the data bus and mapping PSLVERR to an ERROR response.
module ahb3lite_apb_bridge
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [HADDR_SIZE-1:0]  HADDR,
  input  logic [HDATA_SIZE-1:0]  HWDATA,
  output logic [HDATA_SIZE-1:0]  HRDATA,
  input  logic                   HWRITE,
  input  logic [HSIZE_SIZE-1:0]  HSIZE,
  input  logic [HBURST_SIZE-1:0] HBURST,
  input  logic [HPROT_SIZE-1:0]  HPROT,
  input  logic [HTRANS_SIZE-1:0] HTRANS,
  input  logic                   HMASTLOCK,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [PADDR_SIZE-1:0]  PADDR,
  output logic [PDATA_SIZE-1:0]  PWDATA,
  input  logic [PDATA_SIZE-1:0]  PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  output bridge_state_t          state
);

  localparam int unsigned HBYTES = HDATA_SIZE / 8;
  localparam int unsigned PBYTES = PDATA_SIZE / 8;
  localparam int unsigned LANES  = HDATA_SIZE / PDATA_SIZE;

  logic [HADDR_SIZE-1:0] haddr_q;
  logic                  hwrite_q;
  logic [HSIZE_SIZE-1:0] hsize_q;
  logic                  accept;
  logic                  legal;
  int unsigned           lane;
  logic [PDATA_SIZE-1:0] wdata_lane;
  logic                  unused;

  assign accept = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign legal  = size_legal(HSIZE, PBYTES);
  // The lane comes from the latched address: HADDR already belongs to the next beat.
  assign lane   = lane_index(32'(haddr_q), HBYTES, PBYTES);
  assign unused = ^{HBURST, HPROT, HMASTLOCK, hsize_q, haddr_q};

  always_comb begin
    wdata_lane = HWDATA[PDATA_SIZE-1:0];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane == i) wdata_lane = HWDATA[i*PDATA_SIZE +: PDATA_SIZE];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= '0;
    end else begin
      case (state)
        ST_LATCH: begin
          PWDATA <= wdata_lane;
          PADDR  <= haddr_q[PADDR_SIZE-1:0];
          PWRITE <= 1'b1;
          PSEL   <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PSLVERR) begin
              HRESP <= HRESP_ERROR;
              state <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              if (!hwrite_q) HRDATA <= {LANES{PRDATA}};
              state <= ST_IDLE;
            end
          end
        end
        ST_ERR1: begin
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
        default: begin
          // IDLE and ERR2 both sample a new address phase.
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          state     <= ST_IDLE;
          if (accept) begin
            haddr_q   <= HADDR;
            hwrite_q  <= HWRITE;
            hsize_q   <= HSIZE;
            HREADYOUT <= 1'b0;
            if (!legal) begin
              HRESP <= HRESP_ERROR;
              state <= ST_ERR1;
            end else if (HWRITE) begin
              state <= ST_LATCH;
            end else begin
              PSEL    <= 1'b1;
              PENABLE <= 1'b0;
              PWRITE  <= 1'b0;
              PADDR   <= HADDR[PADDR_SIZE-1:0];
              state   <= ST_SETUP;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Directed bench for the AHB3-Lite to APB3 bridge (32-bit AHB, 8-bit APB).
module tb_ahb3lite_apb_bridge;
  import ahb3lite_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  bridge_state_t state;

  int checks = 0;
  int errors = 0;

  ahb3lite_apb_bridge #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(8), .PDATA_SIZE(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .state(state)
  );

  // Single-slave bus: the bus-level ready is the bridge's own ready.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_BYTE; HADDR = '0;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [1:0] tr);
    HSEL = 1'b1; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a;
  endtask

  task automatic test_reset;
    HRESET = 1'b1; idle_bus(); HWDATA = '0; HBURST = '0; HPROT = '0; HMASTLOCK = 1'b0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    tick(); tick();
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %0h exp 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got %0h exp 0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %0h exp 0", HRDATA); end
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin errors++; $display("FAIL rst_apb_ctrl got %b%b%b exp 000", PSEL, PENABLE, PWRITE); end
    checks++; if (PADDR !== 8'h0 || PWDATA !== 8'h0) begin errors++; $display("FAIL rst_apb_bus got %0h/%0h exp 0/0", PADDR, PWDATA); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", state, ST_IDLE); end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_byte;
    PREADY = 1'b1; PSLVERR = 1'b0;
    addr_phase(1'b1, HSIZE_BYTE, 32'h1002, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'hAABBCCDD; idle_bus();
    checks++; if (HREADYOUT !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL wr_latch got hro=%0h psel=%0h exp 0/0", HREADYOUT, PSEL); end
    tick();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL wr_setup_ctrl got psel=%0h pen=%0h hro=%0h exp 1/0/0", PSEL, PENABLE, HREADYOUT); end
    checks++; if (PADDR !== 8'h02) begin errors++; $display("FAIL wr_setup_paddr got %0h exp 02", PADDR); end
    checks++; if (PWDATA !== 8'hBB) begin errors++; $display("FAIL wr_setup_pwdata got %0h exp bb", PWDATA); end
    checks++; if (PWRITE !== 1'b1) begin errors++; $display("FAIL wr_setup_pwrite got %0h exp 1", PWRITE); end
    tick();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || HREADYOUT !== 1'b0 || PWDATA !== 8'hBB || PADDR !== 8'h02) begin errors++; $display("FAIL wr_access got psel=%0h pen=%0h hro=%0h pwdata=%0h paddr=%0h exp 1/1/0/bb/02", PSEL, PENABLE, HREADYOUT, PWDATA, PADDR); end
    tick();
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL wr_done got hro=%0h hresp=%0h exp 1/0", HREADYOUT, HRESP); end
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL wr_done_apb got psel=%0h pen=%0h exp 0/0", PSEL, PENABLE); end
  endtask

  task automatic test_read_wait;
    int ws;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h5A;
    addr_phase(1'b0, HSIZE_BYTE, 32'h05, HTRANS_NONSEQ);
    tick();
    idle_bus();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== 8'h05) begin errors++; $display("FAIL rd_setup got psel=%0h pen=%0h pwrite=%0h paddr=%0h exp 1/0/0/05", PSEL, PENABLE, PWRITE, PADDR); end
    ws = 1;
    while (HREADYOUT !== 1'b1 && ws < 50) begin
      if (ws == 4) PREADY = 1'b1;
      tick();
      ws++;
    end
    checks++; if (ws !== 5) begin errors++; $display("FAIL rd_wait_states got %0d exp 5", ws); end
    checks++; if (HRDATA !== 32'h5A5A5A5A) begin errors++; $display("FAIL rd_hrdata got %0h exp 5a5a5a5a", HRDATA); end
    checks++; if (HRESP !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL rd_done got hresp=%0h psel=%0h exp 0/0", HRESP, PSEL); end
    PREADY = 1'b1;
  endtask

  task automatic test_illegal_size;
    bit psel_seen;
    psel_seen = 1'b0;
    addr_phase(1'b1, HSIZE_WORD, 32'h10, HTRANS_NONSEQ);
    tick();
    idle_bus(); HWDATA = 32'h12345678;
    psel_seen |= PSEL;
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL ill_err1 got hresp=%0h hro=%0h exp 1/0", HRESP, HREADYOUT); end
    tick();
    psel_seen |= PSEL;
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL ill_err2 got hresp=%0h hro=%0h exp 1/1", HRESP, HREADYOUT); end
    // Another illegal transfer offered during ERR2 goes straight back to ERR1.
    addr_phase(1'b0, HSIZE_HWORD, 32'h11, HTRANS_NONSEQ);
    tick();
    idle_bus();
    psel_seen |= PSEL;
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL ill_err2_reerr got hresp=%0h hro=%0h exp 1/0", HRESP, HREADYOUT); end
    tick();
    psel_seen |= PSEL;
    tick();
    psel_seen |= PSEL;
    checks++; if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL ill_back_idle got hresp=%0h hro=%0h exp 0/1", HRESP, HREADYOUT); end
    checks++; if (psel_seen !== 1'b0) begin errors++; $display("FAIL ill_no_psel got %0h exp 0", psel_seen); end
  endtask

  task automatic test_pslverr;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 8'hEE;
    addr_phase(1'b0, HSIZE_BYTE, 32'h03, HTRANS_NONSEQ);
    tick();
    idle_bus();
    tick();
    tick();
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL slverr_err1 got hresp=%0h hro=%0h psel=%0h exp 1/0/0", HRESP, HREADYOUT, PSEL); end
    PSLVERR = 1'b0; PRDATA = 8'h3C;
    tick();
    checks++; if (HRESP !== 1'b1 || HREADYOUT !== 1'b1) begin errors++; $display("FAIL slverr_err2 got hresp=%0h hro=%0h exp 1/1", HRESP, HREADYOUT); end
    addr_phase(1'b0, HSIZE_BYTE, 32'h07, HTRANS_NONSEQ);
    tick();
    idle_bus();
    checks++; if (PSEL !== 1'b1 || PADDR !== 8'h07 || HRESP !== 1'b0 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL slverr_next_setup got psel=%0h paddr=%0h hresp=%0h hro=%0h exp 1/07/0/0", PSEL, PADDR, HRESP, HREADYOUT); end
    tick();
    tick();
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h3C3C3C3C) begin errors++; $display("FAIL slverr_next_done got hro=%0h hresp=%0h hrdata=%0h exp 1/0/3c3c3c3c", HREADYOUT, HRESP, HRDATA); end
  endtask

  task automatic test_back_to_back;
    PREADY = 1'b1; PSLVERR = 1'b0;
    addr_phase(1'b1, HSIZE_BYTE, 32'h0, HTRANS_NONSEQ);
    tick();
    HWDATA = 32'h11223344; idle_bus();
    tick();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 8'h00 || PWDATA !== 8'h44) begin errors++; $display("FAIL b2b_first_setup got psel=%0h pen=%0h paddr=%0h pwdata=%0h exp 1/0/00/44", PSEL, PENABLE, PADDR, PWDATA); end
    // Next address phase is presented during the last data-phase cycle.
    addr_phase(1'b1, HSIZE_BYTE, 32'h1, HTRANS_NONSEQ);
    tick();
    checks++; if (PENABLE !== 1'b1 || HREADYOUT !== 1'b0) begin errors++; $display("FAIL b2b_first_access got pen=%0h hro=%0h exp 1/0", PENABLE, HREADYOUT); end
    tick();
    checks++; if (HREADYOUT !== 1'b1 || PSEL !== 1'b0) begin errors++; $display("FAIL b2b_first_done got hro=%0h psel=%0h exp 1/0", HREADYOUT, PSEL); end
    tick();
    HWDATA = 32'h55667788; idle_bus();
    checks++; if (HREADYOUT !== 1'b0 || state !== ST_LATCH) begin errors++; $display("FAIL b2b_second_accept got hro=%0h state=%0d exp 0/%0d", HREADYOUT, state, ST_LATCH); end
    tick();
    checks++; if (PSEL !== 1'b1 || PADDR !== 8'h01 || PWDATA !== 8'h77) begin errors++; $display("FAIL b2b_second_setup got psel=%0h paddr=%0h pwdata=%0h exp 1/01/77", PSEL, PADDR, PWDATA); end
    tick();
    tick();
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL b2b_second_done got hro=%0h hresp=%0h psel=%0h exp 1/0/0", HREADYOUT, HRESP, PSEL); end
  endtask

  task automatic test_busy_unselected;
    addr_phase(1'b1, HSIZE_BYTE, 32'h2, HTRANS_BUSY);
    tick();
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin errors++; $display("FAIL busy got hro=%0h hresp=%0h psel=%0h exp 1/0/0", HREADYOUT, HRESP, PSEL); end
    addr_phase(1'b0, HSIZE_BYTE, 32'h2, HTRANS_NONSEQ);
    HSEL = 1'b0;
    tick();
    idle_bus();
    checks++; if (HREADYOUT !== 1'b1 || PSEL !== 1'b0 || state !== ST_IDLE) begin errors++; $display("FAIL unselected got hro=%0h psel=%0h state=%0d exp 1/0/0", HREADYOUT, PSEL, state); end
  endtask

  task automatic test_reset_mid_access;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'hC3;
    addr_phase(1'b0, HSIZE_BYTE, 32'h06, HTRANS_NONSEQ);
    tick();
    idle_bus();
    tick();
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got psel=%0h pen=%0h exp 1/1", PSEL, PENABLE); end
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL rstmid_abort got psel=%0h pen=%0h hro=%0h hresp=%0h exp 0/0/1/0", PSEL, PENABLE, HREADYOUT, HRESP); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state got %0d exp 0", state); end
    PREADY = 1'b1;
    addr_phase(1'b0, HSIZE_BYTE, 32'h02, HTRANS_NONSEQ);
    tick();
    idle_bus();
    tick();
    tick();
    checks++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hC3C3C3C3) begin errors++; $display("FAIL rstmid_recover got hro=%0h hrdata=%0h exp 1/c3c3c3c3", HREADYOUT, HRDATA); end
  endtask

  initial begin
    test_reset();
    test_write_byte();
    test_read_wait();
    test_illegal_size();
    test_pslverr();
    test_back_to_back();
    test_busy_unselected();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
